// File: rtl/sram_pkg.sv
// Shared types and widths for the SRAM access controller.
// The optional one-entry read buffer is enabled by SRAM_LAST_READ_BUFFER_EN.
package sram_pkg;

    localparam int SRAM_DATA_W = 16;
    localparam int WORD_W      = 32;

    // Access sequencer states: a word access is IDLE -> LOW -> HIGH -> DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_access_controller_if.sv
// Bundles the pipeline-side request/response signals and the SRAM pad signals.
// slave: the controller; master: the pipeline plus SRAM pads driving it.
interface sram_access_controller_if #(
    parameter int SRAM_ADDR_W = 18
);
    import sram_pkg::*;

    logic                   memoryReadEnabled;
    logic                   memoryWriteEnabled;
    logic [WORD_W-1:0]      address;
    logic [WORD_W-1:0]      writeData;
    logic [WORD_W-1:0]      readData;
    logic                   ready;
    logic                   freeze;
    logic [SRAM_ADDR_W-1:0] sramAddr;
    logic [SRAM_DATA_W-1:0] sramDataOut;
    logic [SRAM_DATA_W-1:0] sramDataIn;
    logic                   sramDataOe;
    logic                   sramWeN;

    modport slave (
        input  memoryReadEnabled, memoryWriteEnabled, address, writeData, sramDataIn,
        output readData, ready, freeze, sramAddr, sramDataOut, sramDataOe, sramWeN
    );

    modport master (
        output memoryReadEnabled, memoryWriteEnabled, address, writeData, sramDataIn,
        input  readData, ready, freeze, sramAddr, sramDataOut, sramDataOe, sramWeN
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Down-counter timing one half-word phase: load on phase entry, then count
// down to zero and hold there (no wrap-around).
module sram_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_reg;

    // Load takes priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/sram_access_controller.sv
// Splits each 32-bit load/store into two 16-bit phases on an async SRAM and
// freezes the pipeline while the access is in flight.
// Optional feature: SRAM_LAST_READ_BUFFER_EN adds a one-entry last-read buffer
// so a repeated read of the same word completes without touching the SRAM.
module sram_access_controller
    import sram_pkg::*;
#(
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_access_controller_if.slave bus
);

    localparam int         IDX_W     = SRAM_ADDR_W - 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t                 state_reg;
    logic                   op_write_reg;
    logic [IDX_W-1:0]       index_reg;
    logic [WORD_W-1:0]      wdata_reg;
    logic [WORD_W-1:0]      read_data_reg;
    logic                   ready_reg;
    logic [SRAM_ADDR_W-1:0] sram_addr_reg;
    logic [SRAM_DATA_W-1:0] sram_dout_reg;
    logic                   sram_oe_reg;
    logic                   sram_we_n_reg;

    logic                   req;
    logic [IDX_W-1:0]       index_in;
    logic                   buf_hit;
    logic [WORD_W-1:0]      buf_data;
    logic                   ctr_load;
    logic                   ctr_dec;
    logic                   ctr_zero;

    assign req      = bus.memoryReadEnabled | bus.memoryWriteEnabled;
    assign index_in = bus.address[SRAM_ADDR_W:2];

    // Byte-offset and out-of-range address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.address[WORD_W-1:SRAM_ADDR_W+1], bus.address[1:0]};

    sram_wait_counter #(.WIDTH(4)) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (ctr_load),
        .load_value (WAIT_LOAD),
        .dec        (ctr_dec),
        .zero       (ctr_zero)
    );

    // Counter control: reload at the start of each phase, count down inside it.
    always_comb begin
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        case (state_reg)
            IDLE:    ctr_load = req & ~buf_hit;
            LOW:     begin
                         ctr_load = ctr_zero;
                         ctr_dec  = ~ctr_zero;
                     end
            HIGH:    ctr_dec = ~ctr_zero;
            default: ;
        endcase
    end

`ifdef SRAM_LAST_READ_BUFFER_EN
    logic              buf_valid_reg;
    logic [IDX_W-1:0]  buf_index_reg;
    logic [WORD_W-1:0] buf_data_reg;

    // Only a pure read can be served from the buffer; both enables means write.
    assign buf_hit  = buf_valid_reg & (buf_index_reg == index_in)
                    & bus.memoryReadEnabled & ~bus.memoryWriteEnabled;
    assign buf_data = buf_data_reg;

    // Fill on a completed read; keep coherent when a write hits the same word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid_reg <= 1'b0;
            buf_index_reg <= '0;
            buf_data_reg  <= '0;
        end else if ((state_reg == HIGH) && ctr_zero) begin
            if (!op_write_reg) begin
                buf_valid_reg <= 1'b1;
                buf_index_reg <= index_reg;
                buf_data_reg  <= {bus.sramDataIn, read_data_reg[15:0]};
            end else if (buf_valid_reg && (buf_index_reg == index_reg)) begin
                buf_data_reg  <= wdata_reg;
            end
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // Access sequencer with registered pad and response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            op_write_reg  <= 1'b0;
            index_reg     <= '0;
            wdata_reg     <= '0;
            read_data_reg <= '0;
            ready_reg     <= 1'b0;
            sram_addr_reg <= '0;
            sram_dout_reg <= '0;
            sram_oe_reg   <= 1'b0;
            sram_we_n_reg <= 1'b1;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (buf_hit) begin
                        state_reg     <= DONE;
                        ready_reg     <= 1'b1;
                        read_data_reg <= buf_data;
                    end else if (req) begin
                        state_reg     <= LOW;
                        op_write_reg  <= bus.memoryWriteEnabled;
                        index_reg     <= index_in;
                        wdata_reg     <= bus.writeData;
                        sram_addr_reg <= {index_in, 1'b0};
                        sram_dout_reg <= bus.writeData[15:0];
                        sram_oe_reg   <= bus.memoryWriteEnabled;
                        sram_we_n_reg <= ~bus.memoryWriteEnabled;
                    end
                end
                LOW: begin
                    if (ctr_zero) begin
                        if (!op_write_reg) begin
                            read_data_reg[15:0] <= bus.sramDataIn;
                        end
                        state_reg     <= HIGH;
                        sram_addr_reg <= {index_reg, 1'b1};
                        sram_dout_reg <= wdata_reg[31:16];
                    end
                end
                HIGH: begin
                    if (ctr_zero) begin
                        if (!op_write_reg) begin
                            read_data_reg[31:16] <= bus.sramDataIn;
                        end
                        state_reg     <= DONE;
                        ready_reg     <= 1'b1;
                        sram_oe_reg   <= 1'b0;
                        sram_we_n_reg <= 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.readData    = read_data_reg;
    assign bus.ready       = ready_reg;
    assign bus.sramAddr    = sram_addr_reg;
    assign bus.sramDataOut = sram_dout_reg;
    assign bus.sramDataOe  = sram_oe_reg;
    assign bus.sramWeN     = sram_we_n_reg;
    // Release the pipeline in the DONE cycle; never hold it during reset.
    assign bus.freeze      = rst & req & ~ready_reg;

endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench for sram_access_controller with a read-data scoreboard.
// Covers the SRAM_LAST_READ_BUFFER_EN build as well as the default build.
module tb_sram_access_controller;
    import sram_pkg::*;

    logic clk;
    logic rst;

    sram_access_controller_if #(.SRAM_ADDR_W(18)) bus_a ();
    sram_access_controller_if #(.SRAM_ADDR_W(18)) bus_b ();

    sram_access_controller #(.SRAM_ADDR_W(18), .WAIT_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    sram_access_controller #(.SRAM_ADDR_W(18), .WAIT_CYCLES(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM models: combinational read, write while WE_n is low.
    logic [15:0] mem_a [0:(1<<18)-1];
    logic [15:0] mem_b [0:(1<<18)-1];
    assign bus_a.sramDataIn = mem_a[bus_a.sramAddr];
    assign bus_b.sramDataIn = mem_b[bus_b.sramAddr];

    // SRAM A is preloaded while reset is low; both models capture writes.
    always @(posedge clk) begin
        if (!rst) begin
            mem_a[0] <= 16'hBEEF;
            mem_a[1] <= 16'hDEAD;
        end else if (!bus_a.sramWeN) begin
            mem_a[bus_a.sramAddr] <= bus_a.sramDataOut;
        end
        if (rst && !bus_b.sramWeN) begin
            mem_b[bus_b.sramAddr] <= bus_b.sramDataOut;
        end
    end

    // Observation mux so one access task can drive either instance.
    logic sel_b;
    wire         s_ready = sel_b ? bus_b.ready      : bus_a.ready;
    wire         s_freeze = sel_b ? bus_b.freeze    : bus_a.freeze;
    wire         s_we_n  = sel_b ? bus_b.sramWeN    : bus_a.sramWeN;
    wire [17:0]  s_addr  = sel_b ? bus_b.sramAddr   : bus_a.sramAddr;
    wire [15:0]  s_dout  = sel_b ? bus_b.sramDataOut : bus_a.sramDataOut;
    wire [31:0]  s_rdata = sel_b ? bus_b.readData   : bus_a.readData;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [bit [16:0]];
    logic [17:0] log_addr [$];
    logic [15:0] log_data [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit use_b, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (use_b) begin
            bus_b.memoryReadEnabled  = rd;
            bus_b.memoryWriteEnabled = wr;
            bus_b.address            = a;
            bus_b.writeData          = d;
        end else begin
            bus_a.memoryReadEnabled  = rd;
            bus_a.memoryWriteEnabled = wr;
            bus_a.address            = a;
            bus_a.writeData          = d;
        end
    endtask

    // Issue one access (called just after a rising edge) and follow it to ready.
    task automatic do_access(input bit use_b, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d,
                             output int lat, output int we_cnt, output int addr_chg);
        bit [16:0]   key;
        logic [17:0] prev;
        bit          is_read;
        key     = {use_b, a[17:2]};
        is_read = rd && !wr;
        sel_b   = use_b;
        drive(use_b, rd, wr, a, d);
        if (is_read) exp_q.push_back(ref_mem[key]);
        if (wr) ref_mem[key] = d;
        lat      = -1;
        we_cnt   = 0;
        addr_chg = 0;
        log_addr.delete();
        log_data.delete();
        prev = s_addr;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (s_ready) begin
                lat = c;
                check("freeze_in_done", 64'(s_freeze), 64'(0));
                if (is_read) begin
                    if (exp_q.size() == 0) check("scoreboard_underflow", 64'(1), 64'(0));
                    else check("read_data", 64'(s_rdata), 64'(exp_q.pop_front()));
                end
                break;
            end
            check("freeze_busy", 64'(s_freeze), 64'(1));
            if (!s_we_n) begin
                we_cnt++;
                log_addr.push_back(s_addr);
                log_data.push_back(s_dout);
            end
            if (s_addr != prev) addr_chg++;
            prev = s_addr;
            @(posedge clk);
            #1;
        end
        if (lat < 0) check("ready_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        drive(use_b, 1'b0, 1'b0, a, d);
    endtask

    int lat, wc, ac;

    initial begin
        ref_mem[{1'b0, 16'h0}] = 32'hDEADBEEF;
        sel_b = 1'b0;
        rst   = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state, with a request held high to show freeze is suppressed.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readData",    64'(bus_a.readData),    64'(0));
        check("rst_ready",       64'(bus_a.ready),       64'(0));
        check("rst_sramWeN",     64'(bus_a.sramWeN),     64'(1));
        check("rst_sramDataOe",  64'(bus_a.sramDataOe),  64'(0));
        check("rst_sramAddr",    64'(bus_a.sramAddr),    64'(0));
        check("rst_sramDataOut", 64'(bus_a.sramDataOut), 64'(0));
        check("rst_freeze",      64'(bus_a.freeze),      64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;

        // Read of word 0, then write of 0x8, then read back, all back-to-back.
        do_access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, lat, wc, ac);
        check("read_latency", 64'(lat), 64'(5));
        check("read_no_we",   64'(wc),  64'(0));
        do_access(1'b0, 1'b0, 1'b1, 32'h8, 32'h12345678, lat, wc, ac);
        check("write_latency",  64'(lat), 64'(5));
        check("write_we_count", 64'(wc),  64'(4));
        check("write_log_size", 64'(log_addr.size()), 64'(4));
        if (log_addr.size() == 4) begin
            check("write_lo_addr", 64'(log_addr[0]), 64'(18'h4));
            check("write_lo_data", 64'(log_data[1]), 64'(16'h5678));
            check("write_hi_addr", 64'(log_addr[2]), 64'(18'h5));
            check("write_hi_data", 64'(log_data[3]), 64'(16'h1234));
        end
        do_access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, lat, wc, ac);
        check("b2b_read_latency", 64'(lat), 64'(5));
        repeat (2) @(posedge clk);
        #1;

        // Reset during the HIGH phase of a write aborts it.
        drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hAAAA5555);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_we_before", 64'(bus_a.sramWeN), 64'(0));
        check("abort_freeze_rst", 64'(bus_a.freeze), 64'(0));
        @(negedge clk);
        check("abort_sramWeN",   64'(bus_a.sramWeN),    64'(1));
        check("abort_oe",        64'(bus_a.sramDataOe), 64'(0));
        check("abort_ready",     64'(bus_a.ready),      64'(0));
        check("abort_readData",  64'(bus_a.readData),   64'(0));
        check("abort_state",     64'(dut_a.state_reg),  64'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;

        // Repeated read of word 0: second one is a buffer hit when enabled.
        do_access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, lat, wc, ac);
        check("first_read_latency", 64'(lat), 64'(5));
        do_access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, lat, wc, ac);
`ifdef SRAM_LAST_READ_BUFFER_EN
        check("repeat_read_latency", 64'(lat), 64'(1));
        check("repeat_read_addr_activity", 64'(ac), 64'(0));
        check("repeat_read_we", 64'(wc), 64'(0));
`else
        check("repeat_read_latency", 64'(lat), 64'(5));
`endif

        // WAIT_CYCLES=1 instance: both enables high means write.
        do_access(1'b1, 1'b1, 1'b1, 32'h4, 32'hCAFEF00D, lat, wc, ac);
        check("w1_both_latency",  64'(lat), 64'(3));
        check("w1_both_we_count", 64'(wc),  64'(2));
        do_access(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, lat, wc, ac);
        check("w1_read_latency", 64'(lat), 64'(3));
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
